// File: rtl/decoder_frame_rx.sv
// rtl/decoder_frame_rx.sv - UART-style serial receiver feeding the decoder io_in bus
// Frames are sampled mid-bit; good codewords land in a one-entry valid/ready holding register.
module decoder_frame_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 7,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              sdi,
  output logic [DATA_W-1:0] word_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  logic              r_sync1, r_sync2;
  state_t            r_state, w_state_n;
  logic [TW-1:0]     r_timer, w_timer_n;
  logic [IW-1:0]     r_idx, w_idx_n;
  logic [DATA_W-1:0] r_shift, w_shift_n;
  logic              r_par, w_par_n;
  logic              r_deliver;
  logic              w_deliver, w_perr, w_ferr, w_tick, w_par_bad;

  assign w_tick    = (r_timer == '0);
  assign w_par_bad = (PARITY_EN != 0) && ((^r_shift ^ r_par) != PARITY_ODD[0]);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_sync1 <= sdi;
      r_sync2 <= r_sync1;
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_timer_n = w_tick ? r_timer : r_timer - 1'b1;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_deliver = 1'b0;
    w_perr    = 1'b0;
    w_ferr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_state_n = S_START;
          w_timer_n = HALF_LOAD;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (!r_sync2) begin
            w_state_n = S_DATA;
            w_timer_n = FULL_LOAD;
            w_idx_n   = '0;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_n[r_idx] = r_sync2;
          w_timer_n        = FULL_LOAD;
          if (r_idx == LAST_IDX) begin
            w_state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_n = r_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_par_n   = r_sync2;
          w_timer_n = FULL_LOAD;
          w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        // A low stop bit outranks a parity mismatch: one pulse per frame.
        if (w_tick) begin
          if (!r_sync2) begin
            w_ferr    = 1'b1;
            w_state_n = S_BREAK;
          end else if (w_par_bad) begin
            w_perr    = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_deliver = 1'b1;
            w_state_n = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (r_sync2) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_deliver    <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      word_o       <= '0;
      valid_o      <= 1'b0;
    end else begin
      r_deliver    <= w_deliver;
      parity_err_o <= w_perr;
      frame_err_o  <= w_ferr;
      overrun_o    <= 1'b0;
      if (r_deliver) begin
        if (!valid_o || ready_i) begin
          word_o  <= r_shift;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decoder_frame_rx.sv
// tb/tb_decoder_frame_rx.sv - randomized self-checking bench for decoder_frame_rx
module tb_decoder_frame_rx;

  localparam int CPB = 16;
  localparam int DW  = 7;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          sdi = 1'b1;
  logic          ready_i = 1'b1;
  logic [DW-1:0] word_o;
  logic          valid_o, parity_err_o, frame_err_o, overrun_o;

  decoder_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clock(clock), .rst_n(rst_n), .sdi(sdi), .word_o(word_o), .valid_o(valid_o),
    .ready_i(ready_i), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int n_valid, n_vhigh, n_perr, n_ferr, n_ovr, n_bad_pulse, rise_cyc, fall_cyc;
  logic [DW-1:0] last_word;
  logic p_valid, p_perr, p_ferr, p_ovr;

  always @(posedge clock) cyc <= cyc + 1;

  // Passive monitor: counts rising edges, flags pulses wider than one cycle
  // and error pulses that land on a valid_o rising edge.
  initial begin
    n_bad_pulse = 0;
    p_valid = 0; p_perr = 0; p_ferr = 0; p_ovr = 0;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        p_valid = 0; p_perr = 0; p_ferr = 0; p_ovr = 0;
      end else begin
        if (valid_o) n_vhigh++;
        if (valid_o && !p_valid) begin
          n_valid++;
          last_word = word_o;
          rise_cyc = cyc;
          if (parity_err_o || frame_err_o) n_bad_pulse++;
        end
        if (parity_err_o && !p_perr) n_perr++;
        if (frame_err_o && !p_ferr) n_ferr++;
        if (overrun_o && !p_ovr) n_ovr++;
        if ((parity_err_o && p_perr) || (frame_err_o && p_ferr) || (overrun_o && p_ovr)) n_bad_pulse++;
        p_valid = valid_o; p_perr = parity_err_o; p_ferr = frame_err_o; p_ovr = overrun_o;
      end
    end
  end

  function automatic logic ref_even_parity(input logic [DW-1:0] d);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += d[i];
    return logic'(ones % 2);
  endfunction

  task automatic clear_counts();
    n_valid = 0; n_vhigh = 0; n_perr = 0; n_ferr = 0; n_ovr = 0;
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stop, input int extra_low);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int j = 0; j < DW; j++) send_bit(d[j]);
    send_bit(pbit);
    send_bit(stop);
    repeat (extra_low) @(negedge clock);
    sdi = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({word_o, valid_o, parity_err_o, frame_err_o, overrun_o} !== '0)
      $display("FAIL reset_outputs got=%b want=0", {word_o, valid_o, parity_err_o, frame_err_o, overrun_o});
    else passed++;
    rst_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_basic();
    ready_i = 1'b1;
    clear_counts();
    send_frame(7'b1110001, 1'b0, 1'b1, 0);
    total++;
    if (n_valid !== 1 || last_word !== 7'b1110001)
      $display("FAIL basic_word got n=%0d word=%b want n=1 word=1110001", n_valid, last_word);
    else passed++;
    total++;
    if (n_vhigh !== 1) $display("FAIL basic_valid_width got=%0d want=1", n_vhigh);
    else passed++;
    // sdi falls at edge fall_cyc+1; valid_o must be set by the edge 155 later.
    total++;
    if (rise_cyc - fall_cyc - 1 !== 155)
      $display("FAIL basic_latency got=%0d want=155", rise_cyc - fall_cyc - 1);
    else passed++;
    total++;
    if (n_perr + n_ferr + n_ovr !== 0) $display("FAIL basic_no_errors got=%0d want=0", n_perr + n_ferr + n_ovr);
    else passed++;
  endtask

  task automatic test_parity_err();
    clear_counts();
    send_frame(7'b1110001, 1'b1, 1'b1, 0);
    total++;
    if (n_perr !== 1 || n_valid !== 0)
      $display("FAIL parity_err got perr=%0d valid=%0d want perr=1 valid=0", n_perr, n_valid);
    else passed++;
    clear_counts();
    send_frame(7'b0000101, ref_even_parity(7'b0000101), 1'b1, 0);
    total++;
    if (n_valid !== 1 || last_word !== 7'b0000101 || n_perr !== 0)
      $display("FAIL parity_recover got n=%0d word=%b perr=%0d want n=1 word=0000101 perr=0", n_valid, last_word, n_perr);
    else passed++;
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_frame(7'b1110001, 1'b0, 1'b0, 40);
    total++;
    if (n_ferr !== 1 || n_perr !== 0 || n_valid !== 0)
      $display("FAIL frame_err got ferr=%0d perr=%0d valid=%0d want 1/0/0", n_ferr, n_perr, n_valid);
    else passed++;
    send_frame(7'b1010101, ref_even_parity(7'b1010101), 1'b1, 0);
    total++;
    if (n_valid !== 1 || last_word !== 7'b1010101 || n_ferr !== 1 || n_perr !== 0)
      $display("FAIL frame_recover got n=%0d word=%b ferr=%0d perr=%0d want n=1 word=1010101 ferr=1 perr=0", n_valid, last_word, n_ferr, n_perr);
    else passed++;
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b0;
    clear_counts();
    send_frame(7'b0000001, ref_even_parity(7'b0000001), 1'b1, 0);
    send_frame(7'b1111110, ref_even_parity(7'b1111110), 1'b1, 0);
    total++;
    if (word_o !== 7'b0000001 || valid_o !== 1'b1)
      $display("FAIL overrun_hold got word=%b valid=%b want word=0000001 valid=1", word_o, valid_o);
    else passed++;
    total++;
    if (n_ovr !== 1 || n_valid !== 1)
      $display("FAIL overrun_pulse got ovr=%0d n=%0d want ovr=1 n=1", n_ovr, n_valid);
    else passed++;
    ready_i = 1'b1;
    @(negedge clock);
    total++;
    if (valid_o !== 1'b0) $display("FAIL overrun_release got valid=%b want 0", valid_o);
    else passed++;
  endtask

  task automatic test_glitch();
    logic [DW-1:0] d;
    clear_counts();
    sdi = 1'b0;
    repeat (5) @(negedge clock);
    sdi = 1'b1;
    repeat (30) @(negedge clock);
    total++;
    if (n_valid + n_perr + n_ferr + n_ovr !== 0 || valid_o !== 1'b0 || word_o !== 7'b0000001)
      $display("FAIL glitch_reject got events=%0d valid=%b word=%b want 0/0/0000001", n_valid + n_perr + n_ferr + n_ovr, valid_o, word_o);
    else passed++;
    d = DW'($urandom);
    send_frame(d, ref_even_parity(d), 1'b1, 0);
    total++;
    if (n_valid !== 1 || last_word !== d)
      $display("FAIL glitch_recover got n=%0d word=%b want n=1 word=%b", n_valid, last_word, d);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] d;
    d = 7'b0110011;
    send_bit(1'b0);
    for (int j = 0; j < 3; j++) send_bit(d[j]);
    sdi = d[3];
    repeat (CPB / 2) @(negedge clock);
    rst_n = 1'b0;
    sdi = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if ({word_o, valid_o, parity_err_o, frame_err_o, overrun_o} !== '0)
      $display("FAIL midframe_reset_outputs got=%b want=0", {word_o, valid_o, parity_err_o, frame_err_o, overrun_o});
    else passed++;
    rst_n = 1'b1;
    clear_counts();
    repeat (200) @(negedge clock);
    total++;
    if (n_valid + n_perr + n_ferr + n_ovr !== 0)
      $display("FAIL midframe_no_pulse got=%0d want=0", n_valid + n_perr + n_ferr + n_ovr);
    else passed++;
    send_frame(d, ref_even_parity(d), 1'b1, 0);
    total++;
    if (n_valid !== 1 || last_word !== d)
      $display("FAIL midframe_recover got n=%0d word=%b want n=1 word=%b", n_valid, last_word, d);
    else passed++;
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic pbit, good;
    ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      d = DW'($urandom);
      pbit = ref_even_parity(d) ^ ($urandom_range(0, 3) == 0);
      good = (ref_even_parity(d) == pbit);
      clear_counts();
      send_frame(d, pbit, 1'b1, $urandom_range(0, 5) == 0 ? 0 : 0);
      total++;
      if (n_valid !== int'(good) || n_perr !== int'(!good) || n_ferr !== 0)
        $display("FAIL rand_outcome[%0d] got valid=%0d perr=%0d ferr=%0d want %0d/%0d/0", k, n_valid, n_perr, n_ferr, good, !good);
      else passed++;
      if (good) begin
        total++;
        if (last_word !== d) $display("FAIL rand_word[%0d] got=%b want=%b", k, last_word, d);
        else passed++;
      end
    end
  endtask

  initial begin
    clear_counts();
    @(negedge clock);
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_back_to_back();
    test_glitch();
    test_reset_midframe();
    test_random();
    total++;
    if (n_bad_pulse !== 0) $display("FAIL pulse_shape got=%0d want=0", n_bad_pulse);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decoder_frame_rx.md
Name: decoder_frame_rx

Overview:
- Serial front-end stage directly upstream of the decoder core.
- Receives asynchronous UART-style frames on one pin and assembles DATA_W-bit codewords (7 bits by default).
- Checks framing and parity, then presents each good codeword on a one-entry valid/ready holding register that drives the decoder's io_in bus.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Even, minimum 4.
- DATA_W, 7: codeword width in bits. Matches the decoder input width.
- PARITY_EN, 1: 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.

Ports:
- clock  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sdi  in  1  serial data in. Idle-high, asynchronous to clock.
- word_o  out  DATA_W  captured codeword, LSB = first data bit received.
- valid_o  out  1  word_o holds an unconsumed codeword.
- ready_i  in  1  decoder accepts word_o.
- parity_err_o  out  1  one-cycle pulse: frame dropped for parity mismatch.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: good frame dropped because the holding register was full.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled externally):
  - word_o=0, valid_o=0, all error pulses 0.
  - Synchronizer FFs=1; FSM=IDLE; counters=0.
- Input synchronizer:
  - sdi passes through 2 flops; all logic uses the synchronized value sync.
  - Added latency: 2 cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: sync==0 -> START, bit timer = CLKS_PER_BIT/2-1.
- START: at timer==0, re-sample sync.
  - sync==0 -> DATA, timer = CLKS_PER_BIT-1, bit index = 0.
  - sync==1 -> IDLE (glitch rejected, no pulse).
- DATA: at each timer==0, shift sync into bit[index] and reload the timer.
  - After bit DATA_W-1: go to PARITY if PARITY_EN=1, else STOP.
- PARITY: at timer==0, sample the parity bit.
  - Frame is good when XOR(data bits, parity bit) == PARITY_ODD.
- STOP: at timer==0, sample the stop bit.
  - sync==0 -> frame_err_o pulse, frame dropped, go to BREAK. frame_err takes precedence over parity_err; only one pulse per frame.
  - sync==1, parity bad -> parity_err_o pulse, frame dropped, go to IDLE.
  - sync==1, parity good -> deliver the word (see output register), go to IDLE.
- BREAK: stay until sync==1, then go to IDLE. No new start bit is accepted while the line is held low.
- Sampling point: mid-bit. Stop-bit sample occurs (CLKS_PER_BIT/2) + (DATA_W+1+PARITY_EN)*CLKS_PER_BIT cycles after the synchronized falling edge.
- Output register:
  - Delivery takes effect on the edge after the stop sample. word_o/valid_o update at that edge.
  - Handshake: transfer occurs on a cycle with valid_o & ready_i; valid_o drops on the next edge unless reloaded.
  - Delivery while valid_o==0, or while valid_o & ready_i in the same cycle -> load word_o, valid_o=1.
  - Delivery while valid_o & !ready_i -> overrun_o pulse; new word dropped; word_o and valid_o unchanged.
  - word_o is stable while valid_o is high and ready_i is low.
  - ready_i while valid_o==0 has no effect.
- Error pulses are exactly one cycle wide and never coincide with a valid_o rising edge for the same frame.
- Reset mid-frame: all state is discarded immediately; the partial frame produces no pulse after release.

Test Plan:
- CLKS_PER_BIT=16, PARITY_EN=1 even; send data 7'b1110001 LSB first, parity bit 0, stop bit 1; ready_i=1.
  -> word_o=7'b1110001; valid_o high exactly one cycle, rising 155 cycles after the sdi falling edge (2 sync + 8 + 9*16 + 1).
- Same frame with parity bit 1 -> parity_err_o single pulse; valid_o stays 0; next good frame 7'b0000101 is delivered normally.
- Same frame with stop bit 0, sdi held low 40 more cycles -> one frame_err_o pulse; no start is detected until sdi rises; a following frame 7'b1010101 is received correctly.
- ready_i=0; send 7'b0000001 then 7'b1111110 back-to-back.
  -> word_o stays 7'b0000001, valid_o stays 1, one overrun_o pulse.
  -> raise ready_i: valid_o drops the next cycle.
- 5-cycle low glitch on sdi in IDLE -> START aborts; no outputs change; the FSM returns to IDLE.
- Assert rst_n=0 during DATA bit 3 for 2 cycles, release with sdi=1 -> all outputs 0; no error pulse; the next full frame 7'b0110011 is received.
